program_loader: RTL
===================

Name: program_loader

Overview:
- Hardware boot loader that pulls a framed byte stream into MIPS_Pipeline instruction memory.
- Holds the CPU in reset while loading and releases it only after a checksum-verified load.
- Sits between a byte source (UART receiver or bench driver) and the instruction-memory write port.
- It is the writing end of the program image that the processor later fetches and executes.

Parameters:
- ADDR_W, 8, word-address width of instruction memory (256 words).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000, inter-byte timeout limit; used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts the byte; a transfer is rx_valid & rx_ready at posedge.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word index being written.
- imem_wdata  out  32  instruction word, assembled big-endian.
- cpu_hold  out  1  active-high reset request to MIPS_Pipeline.
- load_done  out  1  last load completed with a good checksum.
- err_code  out  2  0 none, 1 checksum mismatch, 2 timeout, 3 reserved.

Behaviour:
- Reset (reset=0, asynchronous) sets: state IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, err_code=0, and clears the byte counter, word counter and checksum.
- Frame format: SYNC_BYTE, LEN, then 4*N payload bytes (MSB first per word), then CSUM.
  - LEN = word count N; LEN=0 means 256 words.
  - CSUM = XOR of all payload bytes.
- IDLE: accepts bytes and discards any that are not SYNC_BYTE. On SYNC_BYTE:
  - go to LEN;
  - set cpu_hold=1, load_done=0, err_code=0;
  - reset address and checksum.
- LEN: the accepted byte is latched as the remaining-word count; go to DATA.
- DATA: each accepted byte shifts into imem_wdata (first byte lands in [31:24]) and is XORed into the checksum. The 4th byte of a word goes to WRITE.
- WRITE: lasts exactly one cycle.
  - imem_we=1, rx_ready=0, imem_addr = current word index.
  - Next cycle: imem_addr increments and the remaining count decrements.
  - If the count reaches zero go to CSUM, else back to DATA.
  - imem_addr wraps modulo 2^ADDR_W; a 256-word frame ends with imem_addr back at 0.
- CSUM: the accepted byte is compared with the running XOR.
  - Match: go to DONE, cpu_hold=0, load_done=1.
  - Mismatch: go to ERR, err_code=1, cpu_hold stays 1.
- DONE: rx_ready=1. Non-sync bytes are dropped; SYNC_BYTE restarts a load exactly as in IDLE, re-asserting cpu_hold the next cycle.
- ERR: same as IDLE; outputs hold until SYNC_BYTE arrives.
- Words written before an error remain in memory; cpu_hold=1 prevents their execution.
- rx_ready is 1 in every state except WRITE. rx_valid with rx_ready=0 is not consumed; the source must hold the byte.
- Latency: imem_we asserts 1 cycle after the 4th byte of a word is accepted. cpu_hold falls 1 cycle after CSUM is accepted.
- Reset asserted mid-frame aborts the load immediately with the reset values above; partial memory writes are not undone.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs in LEN, DATA and CSUM and clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES forces ERR with err_code=2 and cpu_hold=1.
- Undefined: no counter exists, the loader waits indefinitely, and err_code never equals 2.

Decomposition:
- Package loader_pkg holds:
  - the state enum (IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR);
  - err_code constants (ERR_NONE, ERR_CSUM, ERR_TIMEOUT);
  - the default SYNC_BYTE.
- One sub-module: loader_word_assembler, containing the 4-byte shift register, byte counter and XOR accumulator, with a word_ready pulse.
- The FSM, address counter and timeout logic stay in program_loader.

Test Plan:
- Frame A5 02 20 08 00 05 20 09 00 0A 0E, then cycles run until CPU register 8 = 5 and register 9 = 0xA.
  - imem_we pulses twice: addr 0 with 0x20080005, addr 1 with 0x2009000A.
  - cpu_hold falls 1 cycle after 0E is accepted; load_done=1, err_code=0.
- Same frame with CSUM 0x0F -> err_code=1, cpu_hold stays 1, load_done=0; the words were still written.
- Bytes 00 FF then the good frame -> leading junk ignored; result identical to the first scenario.
- rx_valid held high continuously -> rx_ready=0 exactly in each WRITE cycle; no byte lost or duplicated; 4 payload bytes per 5 cycles.
- reset driven low after the 5th payload byte, then the good frame -> all outputs at reset values immediately; the reload succeeds from addr 0.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=20: send A5 02 20 then idle 20 cycles -> err_code=2, cpu_hold=1; a following good frame clears err_code and completes.

Source files
------------

// File: rtl/loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: FSM state encoding, error-code
// constants and the default frame start marker.
// ----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/loader_word_assembler.sv
// ----------------------------------------------------------------------------
// loader_word_assembler
// Shifts payload bytes MSB-first into a 32-bit word, counts bytes within the
// word and keeps the running XOR checksum of every payload byte.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_clear           restart: clears byte counter and checksum
//   i_byte_en         i_byte is a payload byte to absorb this cycle
//   i_byte            payload byte
//   o_word            shift register (first byte of a word ends in [31:24])
//   o_csum            XOR of all payload bytes since the last clear
//   o_word_ready      combinational: this byte completes a word
// ----------------------------------------------------------------------------
module loader_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic [7:0]  o_csum,
    output logic        o_word_ready
);

    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word;
    logic [7:0]  r_csum;

    assign o_word_ready = i_byte_en && (r_byte_cnt == 2'd3);
    assign o_word       = r_word;
    assign o_csum       = r_csum;

    // Byte shift register, byte-in-word counter and checksum accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
            r_csum     <= 8'd0;
        end else if (i_clear) begin
            r_byte_cnt <= 2'd0;
            r_csum     <= 8'd0;
        end else if (i_byte_en) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_word     <= {r_word[23:0], i_byte};
            r_csum     <= r_csum ^ i_byte;
        end
    end

endmodule

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
// Boot loader: receives a framed byte stream (SYNC, LEN, 4*N payload bytes,
// CSUM) and writes it word by word into instruction memory while holding the
// CPU in reset. The CPU is released only after a checksum-verified load.
// Optional macro LOADER_TIMEOUT_EN adds an inter-byte timeout (err_code 2).
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   rx_data/valid     incoming byte stream; rx_ready accepts it
//   imem_we/addr/wdata instruction-memory write port (one-cycle strobe)
//   cpu_hold          active-high reset request to the CPU
//   load_done         last load finished with a good checksum
//   err_code          0 none, 1 checksum mismatch, 2 timeout
// ----------------------------------------------------------------------------
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
`ifdef LOADER_TIMEOUT_EN
    ,parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [1:0]        err_code
);

    state_t            r_state, w_state_nxt;
    logic              r_rx_ready, w_rx_ready_nxt;
    logic              r_imem_we, w_imem_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [8:0]        r_count, w_count_nxt;   // remaining words, 256 fits
    logic              r_cpu_hold, w_cpu_hold_nxt;
    logic              r_load_done, w_load_done_nxt;
    logic [1:0]        r_err, w_err_nxt;

    logic              w_accept;
    logic              w_sync_hit;
    logic              w_byte_en;
    logic              w_word_ready;
    logic [31:0]       w_word;
    logic [7:0]        w_csum;
    logic              w_tmo_hit;

    assign w_accept   = rx_valid && r_rx_ready;
    // Only the waiting states look for a frame start
    assign w_sync_hit = w_accept && (rx_data == SYNC_BYTE) &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_byte_en  = w_accept && (r_state == ST_DATA);

    loader_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (reset),
        .i_clear      (w_sync_hit),
        .i_byte_en    (w_byte_en),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_csum       (w_csum),
        .o_word_ready (w_word_ready)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo_run;

    assign w_tmo_run = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_tmo_hit = w_tmo_run && !w_accept && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    // Inter-byte idle counter; restarts on every accepted byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (w_tmo_run && !w_accept && !w_tmo_hit) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end else begin
            r_tmo <= '0;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        w_state_nxt     = r_state;
        w_rx_ready_nxt  = 1'b1;
        w_imem_we_nxt   = 1'b0;
        w_addr_nxt      = r_addr;
        w_count_nxt     = r_count;
        w_cpu_hold_nxt  = r_cpu_hold;
        w_load_done_nxt = r_load_done;
        w_err_nxt       = r_err;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (w_sync_hit) begin
                    w_state_nxt     = ST_LEN;
                    w_cpu_hold_nxt  = 1'b1;
                    w_load_done_nxt = 1'b0;
                    w_err_nxt       = ERR_NONE;
                    w_addr_nxt      = '0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    // LEN of zero encodes a full 256-word image
                    w_count_nxt = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_DATA: begin
                if (w_word_ready) begin
                    w_state_nxt    = ST_WRITE;
                    w_imem_we_nxt  = 1'b1;
                    w_rx_ready_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_WRITE: begin
                w_addr_nxt  = r_addr + ADDR_W'(1);
                w_count_nxt = r_count - 9'd1;
                if (r_count == 9'd1) begin
                    w_state_nxt = ST_CSUM;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (w_accept) begin
                    if (rx_data == w_csum) begin
                        w_state_nxt     = ST_DONE;
                        w_cpu_hold_nxt  = 1'b0;
                        w_load_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = ERR_CSUM;
                    end
                end else begin
                    w_state_nxt = ST_CSUM;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_cpu_hold_nxt  = 1'b1;
                w_load_done_nxt = 1'b0;
            end
        endcase

        if (w_tmo_hit) begin
            w_state_nxt     = ST_ERR;
            w_err_nxt       = ERR_TIMEOUT;
            w_cpu_hold_nxt  = 1'b1;
            w_load_done_nxt = 1'b0;
            w_rx_ready_nxt  = 1'b1;
            w_imem_we_nxt   = 1'b0;
        end else begin
            w_err_nxt = w_err_nxt;
        end
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rx_ready  <= 1'b1;
            r_imem_we   <= 1'b0;
            r_addr      <= '0;
            r_count     <= 9'd0;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_err       <= ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_rx_ready  <= w_rx_ready_nxt;
            r_imem_we   <= w_imem_we_nxt;
            r_addr      <= w_addr_nxt;
            r_count     <= w_count_nxt;
            r_cpu_hold  <= w_cpu_hold_nxt;
            r_load_done <= w_load_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;
    assign cpu_hold   = r_cpu_hold;
    assign load_done  = r_load_done;
    assign err_code   = r_err;

endmodule
